// File: rtl/shifter_seq_nbit_if.sv
// rtl/shifter_seq_nbit_if.sv - request/result bundle between board inputs and the shifter
interface shifter_seq_nbit_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
);
  logic             start;
  logic [1:0]       mode;
  logic [AMT_W-1:0] amt;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             busy;
  logic             done;

  modport master (
    output start, mode, amt, din,
    input  dout, busy, done
  );

  modport slave (
    input  start, mode, amt, din,
    output dout, busy, done
  );
endinterface

// File: rtl/shifter_seq_nbit.sv
// rtl/shifter_seq_nbit.sv - sequential one-bit-per-clock shifter/rotator
module shifter_seq_nbit #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input logic              clk,
  input logic              rst_n,
  shifter_seq_nbit_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  localparam logic [1:0] M_LSL = 2'b00;
  localparam logic [1:0] M_LSR = 2'b01;
  localparam logic [1:0] M_ASR = 2'b10;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_dout;
  logic [AMT_W-1:0] r_cnt;
  logic [1:0]       r_mode;
  logic             r_start_q;
  logic             w_go;
  logic             w_amt_zero;
  logic             w_busy;
  logic             w_done;
  logic [WIDTH-1:0] w_shifted;

  // Only a fresh rising edge on the level request starts an operation.
  assign w_go       = bus.start & ~r_start_q;
  assign w_amt_zero = (bus.amt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_go) w_next = w_amt_zero ? S_DONE : S_SHIFT;
      S_SHIFT: if (r_cnt == AMT_W'(1)) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_SHIFT: w_busy = 1'b1;
      S_DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (r_mode)
      M_LSL:   w_shifted = {r_dout[WIDTH-2:0], 1'b0};
      M_LSR:   w_shifted = {1'b0, r_dout[WIDTH-1:1]};
      M_ASR:   w_shifted = {r_dout[WIDTH-1], r_dout[WIDTH-1:1]};
      default: w_shifted = {r_dout[0], r_dout[WIDTH-1:1]};
    endcase
  end

  // Operands are captured only on a go in IDLE; later input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout    <= '0;
      r_cnt     <= '0;
      r_mode    <= '0;
      r_start_q <= 1'b0;
    end else begin
      r_start_q <= bus.start;
      case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_dout <= bus.din;
            if (!w_amt_zero) begin
              r_cnt  <= bus.amt;
              r_mode <= bus.mode;
            end
          end
        end
        S_SHIFT: begin
          r_dout <= w_shifted;
          r_cnt  <= r_cnt - AMT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.dout = r_dout;
  assign bus.busy = w_busy;
  assign bus.done = w_done;
endmodule

// File: tb/tb_shifter_seq_nbit.sv
// tb/tb_shifter_seq_nbit.sv - directed vector bench for shifter_seq_nbit
module tb_shifter_seq_nbit;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  shifter_seq_nbit_if #(.WIDTH(8), .AMT_W(4)) bus ();

  shifter_seq_nbit #(.WIDTH(8), .AMT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] din;
    logic [1:0] mode;
    logic [3:0] amt;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Start held high for the whole window: also confirms no retrigger.
  task automatic run_op(input int idx, input logic [7:0] d, input logic [1:0] m,
                        input logic [3:0] a, input logic [7:0] exp);
    int first_done;
    int n_done;
    int n_busy;
    first_done = 0;
    n_done     = 0;
    n_busy     = 0;
    @(negedge clk);
    bus.din   = d;
    bus.mode  = m;
    bus.amt   = a;
    bus.start = 1'b1;
    for (int k = 1; k <= int'(a) + 5; k++) begin
      @(negedge clk);
      if (bus.busy) n_busy++;
      if (bus.done) begin
        n_done++;
        if (first_done == 0) begin
          first_done = k;
          check($sformatf("vec%0d_dout", idx), bus.dout, exp);
        end
      end
    end
    check($sformatf("vec%0d_done_cycle", idx), first_done, int'(a) + 1);
    check($sformatf("vec%0d_done_count", idx), n_done, 1);
    check($sformatf("vec%0d_busy_cycles", idx), n_busy, int'(a) + 1);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check($sformatf("vec%0d_hold", idx), bus.dout, exp);
  endtask

  initial begin
    int n_done;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.mode  = 2'b00;
    bus.amt   = 4'd0;
    bus.din   = 8'h00;

    vecs[0]  = '{8'h96, 2'b00, 4'd3,  8'hB0};
    vecs[1]  = '{8'h96, 2'b10, 4'd2,  8'hE5};
    vecs[2]  = '{8'h96, 2'b01, 4'd2,  8'h25};
    vecs[3]  = '{8'h81, 2'b11, 4'd9,  8'hC0};
    vecs[4]  = '{8'hFF, 2'b00, 4'd10, 8'h00};
    vecs[5]  = '{8'h5A, 2'b01, 4'd0,  8'h5A};
    vecs[6]  = '{8'h80, 2'b10, 4'd15, 8'hFF};
    vecs[7]  = '{8'hFF, 2'b01, 4'd8,  8'h00};
    vecs[8]  = '{8'hA5, 2'b11, 4'd8,  8'hA5};
    vecs[9]  = '{8'h01, 2'b11, 4'd3,  8'h20};
    vecs[10] = '{8'h81, 2'b00, 4'd1,  8'h02};
    vecs[11] = '{8'h70, 2'b10, 4'd3,  8'h0E};
    vecs[12] = '{8'h81, 2'b11, 4'd15, 8'h03};
    vecs[13] = '{8'h3C, 2'b10, 4'd1,  8'h1E};

    #3;
    check("reset_dout", bus.dout, 8'h00);
    check("reset_busy", bus.busy, 1'b0);
    check("reset_done", bus.done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", bus.busy, 1'b0);

    for (int i = 0; i < 14; i++) begin
      run_op(i, vecs[i].din, vecs[i].mode, vecs[i].amt, vecs[i].exp);
    end

    // Asynchronous reset while idle with a nonzero result held.
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_idle_dout", bus.dout, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Re-pulse during SHIFT with changed operands: dropped, one done, original result.
    @(negedge clk);
    bus.din   = 8'h96;
    bus.mode  = 2'b00;
    bus.amt   = 4'd6;
    bus.start = 1'b1;
    n_done    = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 2) begin
        bus.start = 1'b0;
        bus.mode  = 2'b01;
        bus.din   = 8'h00;
        bus.amt   = 4'd1;
      end
      if (k == 3) bus.start = 1'b1;
      if (bus.done) begin
        n_done++;
        check("repulse_dout", bus.dout, 8'h80);
      end
    end
    check("repulse_done_count", n_done, 1);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset in the middle of a long shift aborts at once.
    bus.din   = 8'hFF;
    bus.mode  = 2'b01;
    bus.amt   = 4'd8;
    bus.start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("midshift_busy_before", bus.busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("midshift_rst_dout", bus.dout, 8'h00);
    check("midshift_rst_busy", bus.busy, 1'b0);
    check("midshift_rst_done", bus.done, 1'b0);
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post_rst_idle_busy", bus.busy, 1'b0);
    check("post_rst_idle_dout", bus.dout, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
